posit_align: RTL
================

Name: posit_align

Overview:
- Stage directly downstream of the posit magnitude comparator; feeds the posit mantissa adder.
- Consumes the big/small operand fields and computes each operand's combined scale and the scale difference.
- Right-shifts the small mantissa by that difference into a guard-extended datapath with sticky collection.
- Two-stage pipeline with valid/ready handshake; the add stage receives pre-aligned mantissas.

Parameters:
- ES, 2, exponent field size; scale = regime * 2^ES + exponent.
- MW, 8, mantissa width; hidden bit is included at the MSB.
- GW, 3, guard bits appended below the mantissa (guard, round, sticky).
- SW, 12, signed width of the scale and difference arithmetic.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- big_sign  in  1  sign of the larger-magnitude operand.
- big_regime  in  8  signed regime of the big operand.
- big_exponent  in  8  signed exponent of the big operand; range 0..2^ES-1.
- big_mantissa  in  MW  unsigned mantissa of the big operand.
- small_sign  in  1  sign of the smaller operand.
- small_regime  in  8  signed regime of the small operand.
- small_exponent  in  8  signed exponent of the small operand.
- small_mantissa  in  MW  unsigned mantissa of the small operand.
- small_zero  in  1  small operand is zero.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  result sign, equal to big_sign.
- out_eff_sub  out  1  big_sign XOR small_sign.
- out_scale  out  SW  signed scale of the big operand.
- out_big_mant  out  MW+GW  big_mantissa followed by GW zero bits.
- out_small_mant  out  MW+GW  aligned small mantissa; LSB is OR-ed with sticky.
- out_order_err  out  1  small scale exceeded big scale; result was forced to diff=0.

Behaviour:
- Reset (async, rst_n=0): both stage-valid flags clear; out_valid=0; all data outputs 0; in_ready=1 on the first cycle after release.
- Handshake: a transfer occurs when valid&&ready in the same cycle. Per-stage advance: stage k accepts when its valid=0 or stage k+1 accepts.
  - in_ready = ~s1_valid | s2_accept.
  - Combinational in_ready from out_ready is permitted; no skid buffer.
- Stage 1 (register on input accept):
  - big_scale = sext(big_regime)<<<ES + big_exponent; small_scale likewise; both SW-bit signed.
  - diff = big_scale - small_scale.
  - If diff<0: diff forced to 0 and order_err=1.
  - Register diff, big_scale, signs, both mantissas, small_zero, order_err.
- Stage 2 (register on stage-1 advance):
  - ext = small_mantissa<<GW (MW+GW bits). If diff>=MW+GW: aligned=0, sticky=|small_mantissa.
  - Otherwise: aligned=ext>>diff, sticky=OR of the ext bits shifted out.
  - out_small_mant = aligned | sticky (LSB).
  - small_zero=1 forces out_small_mant=0 regardless of diff.
- Latency: exactly 2 cycles from input accept to out_valid with no stall. Throughput: 1 per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 holds all outputs stable. Stage 1 holds while full. in_ready drops only when both stages are full.
- Simultaneous accept into stage 1 and drain from stage 2 in one cycle: both occur, nothing lost or duplicated.
- Data registers update only on accept; valid flags are the only state reset requires. Data outputs hold while not valid.
- Reset asserted mid-operation discards in-flight pairs; out_valid falls asynchronously.

Test Plan:
- ES=2, big (r=1,e=0,m=0x80), small (r=0,e=3,m=0xC0), signs 0/0, out_ready=1 -> 2 cycles later out_scale=4, out_big_mant=0x400, out_small_mant=0x300, eff_sub=0, order_err=0.
- big (r=0,e=1,m=0xFF), small (r=0,e=0,m=0x81), signs 0/1 (scales 1 vs 0, diff 1) -> out_small_mant=0x204 (0x408>>1, no sticky), eff_sub=1.
- big (r=3,e=0) vs small (r=-1,e=0,m=0x90): scales 12 vs -4, diff 16>=11 -> out_small_mant=0x001 (sticky only); same with small_zero=1 -> 0x000.
- Diff=5, small m=0x81 (big r=1,e=1, small r=0,e=0) -> 0x408>>5=0x020, shifted-out 0x08 nonzero -> out_small_mant=0x021.
- Stream 4 pairs back-to-back, hold out_ready=0 for 3 cycles after first out_valid -> outputs stable, in_ready=0 once both stages full, all 4 results in order with no loss or duplication.
- Small scale > big scale (big r=0,e=0; small r=1,e=0) -> order_err=1, diff treated 0. Pulse rst_n low with 2 pairs in flight -> out_valid=0 immediately; no stale output after release.

Source files
------------

// File: rtl/posit_align.sv
// posit_align: two-stage operand alignment ahead of the posit mantissa adder.
// Stage 1 forms both combined scales and their difference; stage 2 right-shifts
// the small mantissa into a guard-extended field and folds shifted-out bits
// into a sticky LSB. Valid/ready handshake, no skid buffer.
module posit_align #(
  parameter int ES = 2,
  parameter int MW = 8,
  parameter int GW = 3,
  parameter int SW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              big_sign,
  input  logic [7:0]        big_regime,
  input  logic [7:0]        big_exponent,
  input  logic [MW-1:0]     big_mantissa,
  input  logic              small_sign,
  input  logic [7:0]        small_regime,
  input  logic [7:0]        small_exponent,
  input  logic [MW-1:0]     small_mantissa,
  input  logic              small_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic              out_eff_sub,
  output logic [SW-1:0]     out_scale,
  output logic [MW+GW-1:0]  out_big_mant,
  output logic [MW+GW-1:0]  out_small_mant,
  output logic              out_order_err
);

  localparam int EW  = MW + GW;
  localparam int SHW = $clog2(EW);

  logic s1_valid_q, s2_valid_q;
  logic s1_accept, s2_accept;

  logic [SW-1:0] big_scale, small_scale, diff_raw, diff_d;
  logic          order_err_d;

  logic [SW-1:0] s1_diff_q, s1_scale_q;
  logic          s1_big_sign_q, s1_small_sign_q, s1_small_zero_q, s1_order_err_q;
  logic [MW-1:0] s1_big_mant_q, s1_small_mant_q;

  logic [EW-1:0]  ext, aligned, small_mant_d;
  logic [SHW-1:0] shamt;
  logic           sticky;

  // Stage 2 takes a new entry when empty or draining; stage 1 likewise from stage 2.
  assign s2_accept = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s2_accept;
  assign s1_accept = in_valid & in_ready;

  // Combined scales: regime * 2^ES + exponent, sign-extended to SW bits.
  always_comb begin
    big_scale   = ({{(SW-8){big_regime[7]}}, big_regime} << ES)
                + {{(SW-8){big_exponent[7]}}, big_exponent};
    small_scale = ({{(SW-8){small_regime[7]}}, small_regime} << ES)
                + {{(SW-8){small_exponent[7]}}, small_exponent};
    diff_raw    = big_scale - small_scale;
    order_err_d = diff_raw[SW-1];
    diff_d      = order_err_d ? '0 : diff_raw;
  end

  // Stage-1 registers: handshake flag plus captured operand data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_diff_q       <= '0;
      s1_scale_q      <= '0;
      s1_big_sign_q   <= 1'b0;
      s1_small_sign_q <= 1'b0;
      s1_small_zero_q <= 1'b0;
      s1_order_err_q  <= 1'b0;
      s1_big_mant_q   <= '0;
      s1_small_mant_q <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s1_accept) begin
        s1_diff_q       <= diff_d;
        s1_scale_q      <= big_scale;
        s1_big_sign_q   <= big_sign;
        s1_small_sign_q <= small_sign;
        s1_small_zero_q <= small_zero;
        s1_order_err_q  <= order_err_d;
        s1_big_mant_q   <= big_mantissa;
        s1_small_mant_q <= small_mantissa;
      end
    end
  end

  // Alignment shift with sticky collection; shifts past the field keep only sticky.
  always_comb begin
    ext     = {s1_small_mant_q, {GW{1'b0}}};
    aligned = '0;
    sticky  = 1'b0;
    shamt   = '0;
    if (s1_diff_q >= SW'(EW)) begin
      sticky = |s1_small_mant_q;
    end else begin
      shamt   = s1_diff_q[SHW-1:0];
      aligned = ext >> shamt;
      sticky  = |(ext & ~({EW{1'b1}} << shamt));
    end
    small_mant_d = s1_small_zero_q ? '0 : (aligned | {{(EW-1){1'b0}}, sticky});
  end

  // Stage-2 registers drive the outputs directly and hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q     <= 1'b0;
      out_sign       <= 1'b0;
      out_eff_sub    <= 1'b0;
      out_scale      <= '0;
      out_big_mant   <= '0;
      out_small_mant <= '0;
      out_order_err  <= 1'b0;
    end else if (s2_accept) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign       <= s1_big_sign_q;
        out_eff_sub    <= s1_big_sign_q ^ s1_small_sign_q;
        out_scale      <= s1_scale_q;
        out_big_mant   <= {s1_big_mant_q, {GW{1'b0}}};
        out_small_mant <= small_mant_d;
        out_order_err  <= s1_order_err_q;
      end
    end
  end

  assign out_valid = s2_valid_q;

endmodule
